// File: rtl/hcsr04_pkg.sv
// Shared types and default timing for the HC-SR04 ultrasonic ranger.
// Defaults assume a 50 MHz system clock.
package hcsr04_pkg;

    localparam int unsigned CLK_HZ            = 50_000_000;
    localparam int unsigned TRIG_CYCLES_DEF   = 500;
    localparam int unsigned PERIOD_CYCLES_DEF = 3_000_000;
    localparam int unsigned RISE_TO_DEF       = 1_250_000;
    localparam int unsigned MAX_ECHO_DEF      = 1_250_000;
    localparam int unsigned W_DEF             = 32;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } state_e;

endpackage

// File: rtl/hcsr04_ranger_sync_edge.sv
// Two-flop synchroniser for an asynchronous input, with single-cycle rise/fall pulses.
// Reusable for any asynchronous sensor line.
module sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // prev_q is the one-cycle-delayed copy used only for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/hcsr04_ranger.sv
// HC-SR04 initiator: periodic trigger pulses, echo width measurement in clk cycles,
// with one-cycle valid/timeout strobes issued on entry to the hold-off state.
module hcsr04_ranger
    import hcsr04_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES   = TRIG_CYCLES_DEF,
    parameter int unsigned PERIOD_CYCLES = PERIOD_CYCLES_DEF,
    parameter int unsigned RISE_TO       = RISE_TO_DEF,
    parameter int unsigned MAX_ECHO      = MAX_ECHO_DEF,
    parameter int unsigned W             = W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         echo_i,
    output logic         trig_o,
    output logic         busy_o,
    output logic [W-1:0] width_out_o,
    output logic         valid_o,
    output logic         timeout_o
);

    // The period must cover the longest trigger + rise wait + saturated echo so HOLDOFF is always reached
    if ((TRIG_CYCLES == 0) || (RISE_TO == 0) || (MAX_ECHO == 0) ||
        (longint'(PERIOD_CYCLES) <=
         longint'(TRIG_CYCLES) + longint'(RISE_TO) + longint'(MAX_ECHO)) ||
        ((W < 32) && (longint'(PERIOD_CYCLES) >= (longint'(1) << W)))) begin : gBadParams
        $error("hcsr04_ranger: inconsistent timing parameters or W too small");
    end

    localparam logic [W-1:0] ONE         = W'(1);
    localparam logic [W-1:0] TRIG_LAST   = W'(TRIG_CYCLES - 1);
    localparam logic [W-1:0] PERIOD_LAST = W'(PERIOD_CYCLES - 1);
    localparam logic [W-1:0] RISE_LAST   = W'(RISE_TO - 1);
    localparam logic [W-1:0] MAX_WIDTH   = W'(MAX_ECHO);

    state_e         state_q,     state_d;
    logic [W-1:0]   periodCnt_q, periodCnt_d;
    logic [W-1:0]   widthCnt_q,  widthCnt_d;
    logic [W-1:0]   widthOut_q,  widthOut_d;
    logic           trig_q,      trig_d;
    logic           valid_q,     valid_d;
    logic           timeout_q,   timeout_d;

    logic           echoS;
    logic           echoRise;
    logic           echoFall;

    sync_edge uEchoSync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (echo_i),
        .level_o (echoS),
        .rise_o  (echoRise),
        .fall_o  (echoFall)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            periodCnt_q <= '0;
            widthCnt_q  <= '0;
            widthOut_q  <= '0;
            trig_q      <= 1'b0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            periodCnt_q <= periodCnt_d;
            widthCnt_q  <= widthCnt_d;
            widthOut_q  <= widthOut_d;
            trig_q      <= trig_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
        end
    end

    // widthCnt doubles as the rise-wait timer in WAIT_RISE and the echo width counter in MEASURE
    always_comb begin
        state_d     = state_q;
        periodCnt_d = periodCnt_q;
        widthCnt_d  = widthCnt_q;
        widthOut_d  = widthOut_q;
        valid_d     = 1'b0;
        timeout_d   = 1'b0;

        if (state_q != IDLE) begin
            periodCnt_d = periodCnt_q + ONE;
        end

        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d     = TRIG;
                    periodCnt_d = '0;
                end
            end
            TRIG: begin
                if (!enable_i) begin
                    state_d     = IDLE;
                    periodCnt_d = '0;
                end else if (periodCnt_q == TRIG_LAST) begin
                    state_d    = WAIT_RISE;
                    widthCnt_d = '0;
                end
            end
            WAIT_RISE: begin
                if (!enable_i) begin
                    state_d     = IDLE;
                    periodCnt_d = '0;
                end else if (echoRise) begin
                    state_d    = MEASURE;
                    widthCnt_d = ONE;
                end else if (widthCnt_q == RISE_LAST) begin
                    state_d   = HOLDOFF;
                    timeout_d = 1'b1;
                end else begin
                    widthCnt_d = widthCnt_q + ONE;
                end
            end
            MEASURE: begin
                if (!enable_i) begin
                    state_d     = IDLE;
                    periodCnt_d = '0;
                end else if (echoFall) begin
                    state_d    = HOLDOFF;
                    widthOut_d = widthCnt_q;
                    valid_d    = 1'b1;
                end else if (widthCnt_q == MAX_WIDTH) begin
                    state_d    = HOLDOFF;
                    widthOut_d = MAX_WIDTH;
                    valid_d    = 1'b1;
                    timeout_d  = 1'b1;
                end else if (echoS) begin
                    widthCnt_d = widthCnt_q + ONE;
                end
            end
            HOLDOFF: begin
                if (periodCnt_q == PERIOD_LAST) begin
                    periodCnt_d = '0;
                    state_d     = enable_i ? TRIG : IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                periodCnt_d = '0;
            end
        endcase

        trig_d = (state_d == TRIG);
    end

    assign trig_o      = trig_q;
    assign busy_o      = (state_q != IDLE);
    assign width_out_o = widthOut_q;
    assign valid_o     = valid_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_hcsr04_ranger.sv
// Directed self-checking bench for hcsr04_ranger with shortened timing
// (TRIG=5, PERIOD=200, RISE_TO=50, MAX_ECHO=100).
module tb_hcsr04_ranger;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        echo;
    logic        trig;
    logic        busy;
    logic [31:0] widthOut;
    logic        valid;
    logic        timeout;

    int assertCount = 0;
    int failCount   = 0;

    hcsr04_ranger #(
        .TRIG_CYCLES   (5),
        .PERIOD_CYCLES (200),
        .RISE_TO       (50),
        .MAX_ECHO      (100),
        .W             (32)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .echo_i      (echo),
        .trig_o      (trig),
        .busy_o      (busy),
        .width_out_o (widthOut),
        .valid_o     (valid),
        .timeout_o   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a wait loop is broken
    initial begin
        #400_000;
        $display("[TB] FAIL watchdog: observed simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic en, input logic ec);
        enable = en;
        echo   = ec;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Counts negedges until trig reaches the given level (0 if already there)
    task automatic waitTrig(input logic level, input int limit, output int n);
        n = 0;
        while (trig !== level && n < limit) begin
            tick(1);
            n++;
        end
    endtask

    // Counts negedges until valid or timeout is seen
    task automatic waitStrobe(input int limit, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!(valid === 1'b1 || timeout === 1'b1) && n < limit);
    endtask

    initial begin
        int   n;
        int   nValid;
        int   nTimeout;
        logic prevTrig;
        logic rose;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        tick(2);
        $display("[TB] reset state");
        checkOutput("reset trig",    32'(trig),    32'd0);
        checkOutput("reset busy",    32'(busy),    32'd0);
        checkOutput("reset width",   widthOut,     32'd0);
        checkOutput("reset valid",   32'(valid),   32'd0);
        checkOutput("reset timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        tick(2);
        checkOutput("idle busy", 32'(busy), 32'd0);

        $display("[TB] trigger pulse");
        applyStimulus(1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            checkOutput($sformatf("trig cycle %0d", k), 32'(trig), (k <= 5) ? 32'd1 : 32'd0);
        end
        checkOutput("busy after trig", 32'(busy), 32'd1);

        $display("[TB] 40-cycle echo");
        tick(9);
        applyStimulus(1'b1, 1'b1);
        tick(40);
        applyStimulus(1'b1, 1'b0);
        waitStrobe(10, n);
        checkOutput("valid latency", n, 32'd3);
        checkOutput("echo40 valid",   32'(valid),   32'd1);
        checkOutput("echo40 timeout", 32'(timeout), 32'd0);
        checkOutput("echo40 width",   widthOut,     32'd40);
        tick(1);
        checkOutput("echo40 valid one cycle", 32'(valid), 32'd0);

        $display("[TB] no echo");
        waitTrig(1'b1, 300, n);
        checkOutput("second trig rise", n, 32'd142);
        waitTrig(1'b0, 20, n);
        checkOutput("second trig width", n, 32'd5);
        waitStrobe(60, n);
        checkOutput("rise timeout delay", n, 32'd50);
        checkOutput("noecho timeout", 32'(timeout), 32'd1);
        checkOutput("noecho valid",   32'(valid),   32'd0);
        checkOutput("noecho width",   widthOut,     32'd40);
        tick(1);
        checkOutput("noecho timeout one cycle", 32'(timeout), 32'd0);

        $display("[TB] saturated echo");
        waitTrig(1'b1, 300, n);
        waitTrig(1'b0, 20, n);
        applyStimulus(1'b1, 1'b1);
        waitStrobe(120, n);
        checkOutput("saturation delay", n, 32'd103);
        checkOutput("sat valid",   32'(valid),   32'd1);
        checkOutput("sat timeout", 32'(timeout), 32'd1);
        checkOutput("sat width",   widthOut,     32'd100);
        tick(1);
        checkOutput("sat strobes cleared", 32'({valid, timeout}), 32'd0);
        tick(46);
        applyStimulus(1'b1, 1'b0);

        $display("[TB] period spacing, echo during trigger");
        waitTrig(1'b1, 100, n);
        checkOutput("fourth trig rise", n, 32'd45);
        for (int p = 0; p < 5; p++) begin
            applyStimulus(1'b1, 1'b1);
            n        = 0;
            nValid   = 0;
            nTimeout = 0;
            prevTrig = 1'b1;
            rose     = 1'b0;
            do begin
                tick(1);
                n++;
                if (n == 30) applyStimulus(1'b1, 1'b0);
                if (valid === 1'b1) nValid++;
                if (timeout === 1'b1) nTimeout++;
                rose     = (trig === 1'b1) && !prevTrig;
                prevTrig = trig;
            end while (!rose && n < 250);
            checkOutput($sformatf("period %0d spacing", p), n, 32'd200);
            checkOutput($sformatf("period %0d valid count", p), nValid, 32'd0);
            checkOutput($sformatf("period %0d timeout count", p), nTimeout, 32'd1);
        end

        $display("[TB] reset during measure");
        waitTrig(1'b0, 20, n);
        applyStimulus(1'b1, 1'b1);
        tick(10);
        checkOutput("measure busy",        32'(busy), 32'd1);
        checkOutput("width before reset",  widthOut,  32'd100);
        rst = 1'b1;
        #1;
        checkOutput("async reset trig",    32'(trig),    32'd0);
        checkOutput("async reset busy",    32'(busy),    32'd0);
        checkOutput("async reset width",   widthOut,     32'd0);
        checkOutput("async reset valid",   32'(valid),   32'd0);
        checkOutput("async reset timeout", 32'(timeout), 32'd0);
        tick(2);
        applyStimulus(1'b1, 1'b0);
        rst = 1'b0;

        $display("[TB] disable during rise wait");
        waitTrig(1'b1, 10, n);
        checkOutput("restart trig delay", n, 32'd1);
        waitTrig(1'b0, 10, n);
        checkOutput("restart trig width", n, 32'd5);
        tick(10);
        checkOutput("wait rise busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b0);
        tick(1);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort trig", 32'(trig), 32'd0);
        nTimeout = 0;
        for (int k = 0; k < 60; k++) begin
            tick(1);
            if (valid === 1'b1 || timeout === 1'b1 || busy === 1'b1) nTimeout++;
        end
        checkOutput("abort stays idle", nTimeout, 32'd0);
        checkOutput("abort width", widthOut, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
